// File: rtl/ob_ctrl_pkg.sv
// Shared constants for the order-book input path: arbiter state encoding,
// source identifiers and the statistics counter width.
package ob_ctrl_pkg;

    localparam int CNT_W    = 16;
    localparam int ARB_ST_W = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [ARB_ST_W-1:0] ARB_RUN       = 2'd0;
    localparam logic [ARB_ST_W-1:0] ARB_DRAIN     = 2'd1;
    localparam logic [ARB_ST_W-1:0] ARB_DUMP      = 2'd2;
    localparam logic [ARB_ST_W-1:0] ARB_DUMP_WAIT = 2'd3;

    localparam logic SRC_NET = 1'b0;
    localparam logic SRC_BOT = 1'b1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter16
    import ob_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count one event per cycle, holding once saturated
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_inc) begin
            r_count <= sat_inc(r_count);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ob_input_arbiter.sv
// Merges network-FIFO and market-bot order words into the order-book engine,
// dropping zero words, and sequences engine dump requests.
module ob_input_arbiter
    import ob_ctrl_pkg::*;
#(
    parameter int BURST_MAX    = 4,
    parameter int DUMP_TIMEOUT = 1024
) (
    input  logic             clk_engine,
    input  logic             rst_engine,
    input  logic             i_enable,
    input  logic [31:0]      net_dout,
    input  logic             net_empty,
    output logic             net_rd_en,
    input  logic [31:0]      bot_data,
    input  logic             bot_valid,
    output logic             bot_ready,
    input  logic             dump_req,
    input  logic             engine_busy,
    output logic             ob_input_valid,
    output logic [31:0]      ob_input_data,
    output logic             ob_start_dump,
    output logic             o_dump_active,
    output logic [CNT_W-1:0] o_cnt_net,
    output logic [CNT_W-1:0] o_cnt_bot,
    output logic [CNT_W-1:0] o_cnt_nop,
    output logic             o_dump_timeout
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int TW = $clog2(DUMP_TIMEOUT + 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(DUMP_TIMEOUT - 1);
    localparam logic [TW-1:0] WAIT_ONE  = TW'(1);

    logic [ARB_ST_W-1:0] r_state;
    logic [ARB_ST_W-1:0] w_state_nxt;
    logic                r_dump_pending;
    logic                r_last_src;
    logic [BW-1:0]       r_burst_cnt;
    logic                r_busy_seen;
    logic [TW-1:0]       r_wait_cnt;
    logic                r_dump_timeout;
    logic                r_start_dump;
    logic                r_dump_active;
    logic                r_in_valid;
    logic [31:0]         r_in_data;

    logic        w_net_req;
    logic        w_bot_req;
    logic        w_accept_ok;
    logic        w_pick_bot;
    logic        w_grant_src;
    logic        w_accept;
    logic [31:0] w_word;
    logic        w_word_nz;
    logic        w_fwd_net;
    logic        w_fwd_bot;
    logic        w_drop_nop;
    logic        w_busy_done;
    logic        w_timeout_hit;

    assign w_net_req   = ~net_empty;
    assign w_bot_req   = bot_valid;
    assign w_accept_ok = (r_state == ARB_RUN) & i_enable & ~engine_busy & ~rst_engine;

    // Source choice: with both requesting, the last source keeps the grant until its burst is spent
    always_comb begin
        w_pick_bot = 1'b0;
        if (w_net_req && w_bot_req) begin
            if (r_burst_cnt >= BURST_LIM) begin
                w_pick_bot = (r_last_src == SRC_NET);
            end else begin
                w_pick_bot = (r_last_src == SRC_BOT);
            end
        end else if (w_bot_req) begin
            w_pick_bot = 1'b1;
        end else begin
            w_pick_bot = 1'b0;
        end
    end

    assign w_grant_src = w_pick_bot ? SRC_BOT : SRC_NET;
    assign net_rd_en   = w_accept_ok & w_net_req & ~w_pick_bot;
    assign bot_ready   = w_accept_ok & w_bot_req & w_pick_bot;
    assign w_accept    = net_rd_en | bot_ready;
    assign w_word      = bot_ready ? bot_data : net_dout;
    assign w_word_nz   = (w_word != 32'd0);
    assign w_fwd_net   = net_rd_en & w_word_nz;
    assign w_fwd_bot   = bot_ready & w_word_nz;
    assign w_drop_nop  = w_accept & ~w_word_nz;

    assign w_busy_done   = (r_state == ARB_DUMP_WAIT) & r_busy_seen & ~engine_busy;
    assign w_timeout_hit = (r_state == ARB_DUMP_WAIT) & ~r_busy_seen & ~engine_busy
                         & (r_wait_cnt == WAIT_LAST);

    // Dump sequencer next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_RUN: begin
                if (r_dump_pending) w_state_nxt = ARB_DRAIN;
                else                w_state_nxt = ARB_RUN;
            end
            ARB_DRAIN: begin
                if (!engine_busy) w_state_nxt = ARB_DUMP;
                else              w_state_nxt = ARB_DRAIN;
            end
            ARB_DUMP: begin
                w_state_nxt = ARB_DUMP_WAIT;
            end
            ARB_DUMP_WAIT: begin
                if (w_busy_done || w_timeout_hit) w_state_nxt = ARB_RUN;
                else                              w_state_nxt = ARB_DUMP_WAIT;
            end
            default: begin
                w_state_nxt = ARB_RUN;
            end
        endcase
    end

    // Dump sequencing state, pending request flag and DUMP_WAIT supervision
    always_ff @(posedge clk_engine) begin
        if (rst_engine) begin
            r_state        <= ARB_RUN;
            r_dump_pending <= 1'b0;
            r_busy_seen    <= 1'b0;
            r_wait_cnt     <= {TW{1'b0}};
            r_dump_timeout <= 1'b0;
            r_start_dump   <= 1'b0;
            r_dump_active  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            // A request landing in the DUMP cycle belongs to the next dump
            r_dump_pending <= dump_req | (r_dump_pending & (r_state != ARB_DUMP));
            r_start_dump   <= (w_state_nxt == ARB_DUMP);
            r_dump_active  <= (w_state_nxt != ARB_RUN);
            r_dump_timeout <= r_dump_timeout | w_timeout_hit;
            if (r_state == ARB_DUMP_WAIT) begin
                r_busy_seen <= r_busy_seen | engine_busy;
                if (!r_busy_seen && !engine_busy) begin
                    r_wait_cnt <= r_wait_cnt + WAIT_ONE;
                end else begin
                    r_wait_cnt <= r_wait_cnt;
                end
            end else begin
                r_busy_seen <= 1'b0;
                r_wait_cnt  <= {TW{1'b0}};
            end
        end
    end

    // Burst tracking: only forwarded (nonzero) words count toward a burst
    always_ff @(posedge clk_engine) begin
        if (rst_engine) begin
            r_last_src  <= SRC_NET;
            r_burst_cnt <= {BW{1'b0}};
        end else if (w_accept && w_word_nz) begin
            if (w_grant_src == r_last_src) begin
                r_last_src <= r_last_src;
                if (r_burst_cnt < BURST_LIM) r_burst_cnt <= r_burst_cnt + BURST_ONE;
                else                         r_burst_cnt <= r_burst_cnt;
            end else begin
                r_last_src  <= w_grant_src;
                r_burst_cnt <= BURST_ONE;
            end
        end else begin
            r_last_src  <= r_last_src;
            r_burst_cnt <= r_burst_cnt;
        end
    end

    // Engine-side word register; data holds the most recently accepted word
    always_ff @(posedge clk_engine) begin
        if (rst_engine) begin
            r_in_valid <= 1'b0;
            r_in_data  <= 32'd0;
        end else begin
            r_in_valid <= w_accept & w_word_nz;
            if (w_accept) r_in_data <= w_word;
            else          r_in_data <= r_in_data;
        end
    end

    sat_counter16 u_cnt_net (
        .i_clk   (clk_engine),
        .i_rst   (rst_engine),
        .i_inc   (w_fwd_net),
        .o_count (o_cnt_net)
    );

    sat_counter16 u_cnt_bot (
        .i_clk   (clk_engine),
        .i_rst   (rst_engine),
        .i_inc   (w_fwd_bot),
        .o_count (o_cnt_bot)
    );

    sat_counter16 u_cnt_nop (
        .i_clk   (clk_engine),
        .i_rst   (rst_engine),
        .i_inc   (w_drop_nop),
        .o_count (o_cnt_nop)
    );

    assign ob_input_valid = r_in_valid;
    assign ob_input_data  = r_in_data;
    assign ob_start_dump  = r_start_dump;
    assign o_dump_active  = r_dump_active;
    assign o_dump_timeout = r_dump_timeout;

endmodule

// File: tb/tb_ob_input_arbiter.sv
// Bench for ob_input_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level reference model.
module tb_ob_input_arbiter;

    localparam int BURST = 4;
    localparam int TMO   = 1024;

    logic        clk_engine = 1'b0;
    logic        rst_engine;
    logic        i_enable;
    logic [31:0] net_dout;
    logic        net_empty;
    logic        net_rd_en;
    logic [31:0] bot_data;
    logic        bot_valid;
    logic        bot_ready;
    logic        dump_req;
    logic        engine_busy;
    logic        ob_input_valid;
    logic [31:0] ob_input_data;
    logic        ob_start_dump;
    logic        o_dump_active;
    logic [15:0] o_cnt_net;
    logic [15:0] o_cnt_bot;
    logic [15:0] o_cnt_nop;
    logic        o_dump_timeout;

    ob_input_arbiter #(.BURST_MAX(BURST), .DUMP_TIMEOUT(TMO)) dut (
        .clk_engine     (clk_engine),
        .rst_engine     (rst_engine),
        .i_enable       (i_enable),
        .net_dout       (net_dout),
        .net_empty      (net_empty),
        .net_rd_en      (net_rd_en),
        .bot_data       (bot_data),
        .bot_valid      (bot_valid),
        .bot_ready      (bot_ready),
        .dump_req       (dump_req),
        .engine_busy    (engine_busy),
        .ob_input_valid (ob_input_valid),
        .ob_input_data  (ob_input_data),
        .ob_start_dump  (ob_start_dump),
        .o_dump_active  (o_dump_active),
        .o_cnt_net      (o_cnt_net),
        .o_cnt_bot      (o_cnt_bot),
        .o_cnt_nop      (o_cnt_nop),
        .o_dump_timeout (o_dump_timeout)
    );

    always #5 clk_engine = ~clk_engine;

    typedef enum int {M_RUN, M_DRAIN, M_DUMP, M_WAIT} mst_t;

    int          total;
    int          bad;
    logic [31:0] net_q[$];
    logic [31:0] bot_q[$];
    int          grant_log[$];
    logic [31:0] out_log[$];
    bit          log_on;
    bit          stream_mode;
    bit          net_hold;
    bit          bot_hold;
    int          pulses;
    int          active_cycles;

    mst_t        m_st;
    bit          m_pend;
    int          m_last;
    int          m_run;
    bit          m_seen;
    int          m_idle;
    bit          m_tmo;
    int          m_cnt_net;
    int          m_cnt_bot;
    int          m_cnt_nop;
    bit          m_valid;
    logic [31:0] m_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_RUN; m_pend = 1'b0; m_last = 0; m_run = 0; m_seen = 1'b0; m_idle = 0;
        m_tmo = 1'b0; m_cnt_net = 0; m_cnt_bot = 0; m_cnt_nop = 0; m_valid = 1'b0; m_data = 32'd0;
    endtask

    // -1 = nothing accepted, 0 = net, 1 = bot
    function automatic int exp_grant();
        bit nr;
        bit br;
        nr = !net_empty;
        br = bot_valid;
        if (rst_engine || m_st != M_RUN || !i_enable || engine_busy) return -1;
        if (nr && br) return (m_run >= BURST) ? 1 - m_last : m_last;
        if (nr) return 0;
        if (br) return 1;
        return -1;
    endfunction

    task automatic model_step();
        int          g;
        logic [31:0] w;
        mst_t        old_st;
        g = exp_grant();
        if (rst_engine) begin
            model_reset();
            return;
        end
        m_valid = 1'b0;
        if (g >= 0) begin
            w = (g == 1) ? bot_data : net_dout;
            m_data = w;
            if (w != 32'd0) begin
                m_valid = 1'b1;
                if (g == 0) begin
                    if (m_cnt_net < 65535) m_cnt_net++;
                end else begin
                    if (m_cnt_bot < 65535) m_cnt_bot++;
                end
                if (g == m_last) m_run = (m_run < BURST) ? m_run + 1 : BURST;
                else begin m_last = g; m_run = 1; end
            end else if (m_cnt_nop < 65535) begin
                m_cnt_nop++;
            end
            if (g == 0 && !stream_mode) void'(net_q.pop_front());
            if (g == 1) void'(bot_q.pop_front());
        end
        old_st = m_st;
        case (m_st)
            M_RUN:   if (m_pend) m_st = M_DRAIN;
            M_DRAIN: if (!engine_busy) m_st = M_DUMP;
            M_DUMP:  begin m_st = M_WAIT; m_seen = 1'b0; m_idle = 0; end
            M_WAIT: begin
                if (engine_busy) m_seen = 1'b1;
                else if (m_seen) m_st = M_RUN;
                else begin
                    m_idle++;
                    if (m_idle == TMO) begin m_tmo = 1'b1; m_st = M_RUN; end
                end
            end
            default: m_st = M_RUN;
        endcase
        m_pend = (old_st == M_DUMP) ? dump_req : (m_pend | dump_req);
    endtask

    task automatic present();
        if (stream_mode) begin
            net_empty = 1'b0;
            net_dout  = 32'h0000_00A5;
        end else begin
            net_empty = net_hold || (net_q.size() == 0);
            net_dout  = (net_q.size() > 0) ? net_q[0] : 32'd0;
        end
        bot_valid = !bot_hold && (bot_q.size() > 0);
        bot_data  = (bot_q.size() > 0) ? bot_q[0] : 32'd0;
    endtask

    task automatic check_all();
        int g;
        g = exp_grant();
        chk("net_rd_en",    32'(net_rd_en),      32'(g == 0));
        chk("bot_ready",    32'(bot_ready),      32'(g == 1));
        chk("in_valid",     32'(ob_input_valid), 32'(m_valid));
        chk("in_data",      ob_input_data,       m_data);
        chk("start_dump",   32'(ob_start_dump),  32'(m_st == M_DUMP));
        chk("dump_active",  32'(o_dump_active),  32'(m_st != M_RUN));
        chk("cnt_net",      32'(o_cnt_net),      m_cnt_net);
        chk("cnt_bot",      32'(o_cnt_bot),      m_cnt_bot);
        chk("cnt_nop",      32'(o_cnt_nop),      m_cnt_nop);
        chk("dump_timeout", 32'(o_dump_timeout), 32'(m_tmo));
    endtask

    task automatic tick(input bit do_check);
        @(negedge clk_engine);
        if (do_check) check_all();
        if (ob_start_dump) pulses++;
        if (o_dump_active) active_cycles++;
        if (log_on) begin
            grant_log.push_back(net_rd_en ? 0 : (bot_ready ? 1 : 2));
            if (ob_input_valid) out_log.push_back(ob_input_data);
        end
        @(posedge clk_engine);
        #1;
        model_step();
        present();
    endtask

    task automatic do_reset();
        rst_engine = 1'b1; dump_req = 1'b0; engine_busy = 1'b0; i_enable = 1'b1;
        net_hold = 1'b0; bot_hold = 1'b0; stream_mode = 1'b0;
        net_q.delete(); bot_q.delete();
        present();
        repeat (2) tick(1'b1);
        rst_engine = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        total = 0; bad = 0; pulses = 0; active_cycles = 0;
        log_on = 1'b0; stream_mode = 1'b0; net_hold = 1'b0; bot_hold = 1'b0;
        i_enable = 1'b1; engine_busy = 1'b0; dump_req = 1'b0; rst_engine = 1'b1;
        model_reset();
        net_q.push_back(32'h55); bot_q.push_back(32'h66);
        present();

        // Reset holds off accepts even with words waiting
        repeat (3) tick(1'b1);
        chk("rst_no_net_accept", 32'(net_rd_en), 32'd0);
        chk("rst_no_bot_accept", 32'(bot_ready), 32'd0);
        do_reset();
        chk("rst_valid",  32'(ob_input_valid), 32'd0);
        chk("rst_data",   ob_input_data,       32'd0);
        chk("rst_start",  32'(ob_start_dump),  32'd0);
        chk("rst_active", 32'(o_dump_active),  32'd0);
        chk("rst_cnt",    32'(o_cnt_net) + 32'(o_cnt_bot) + 32'(o_cnt_nop), 32'd0);

        // Net only: 0x11, 0x00, 0x22
        net_q.push_back(32'h11); net_q.push_back(32'h00); net_q.push_back(32'h22);
        present();
        log_on = 1'b1; out_log.delete();
        repeat (6) tick(1'b1);
        log_on = 1'b0;
        chk("r031_nfwd", 32'(out_log.size()), 32'd2);
        chk("r031_w0", (out_log.size() > 0) ? out_log[0] : 32'hDEAD_BEEF, 32'h11);
        chk("r031_w1", (out_log.size() > 1) ? out_log[1] : 32'hDEAD_BEEF, 32'h22);
        chk("r031_cnt_net", 32'(o_cnt_net), 32'd2);
        chk("r031_cnt_nop", 32'(o_cnt_nop), 32'd1);

        // Both sources saturated: net x4, bot x4, net x4
        do_reset();
        for (int i = 0; i < 12; i++) begin
            net_q.push_back(32'h100 + 32'(i));
            bot_q.push_back(32'h200 + 32'(i));
        end
        present();
        log_on = 1'b1; grant_log.delete();
        repeat (12) tick(1'b1);
        log_on = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("r032_order%0d", i),
                (grant_log.size() > i) ? 32'(grant_log[i]) : 32'd9, 32'((i / 4) % 2));
        end
        repeat (20) tick(1'b1);

        // Busy engine blocks both sources
        do_reset();
        for (int i = 0; i < 3; i++) begin
            net_q.push_back(32'h300 + 32'(i));
            bot_q.push_back(32'h400 + 32'(i));
        end
        engine_busy = 1'b1;
        present();
        log_on = 1'b1; grant_log.delete();
        repeat (5) tick(1'b1);
        engine_busy = 1'b0;
        tick(1'b1);
        log_on = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) if (grant_log.size() > i && grant_log[i] != 2) n++;
        chk("r033_busy_accepts", 32'(n), 32'd0);
        chk("r033_resume", (grant_log.size() > 5) ? 32'(grant_log[5]) : 32'd9, 32'd0);
        repeat (10) tick(1'b1);

        // Dump while busy, then a second request merged in the DUMP cycle
        do_reset();
        pulses = 0;
        engine_busy = 1'b1;
        dump_req = 1'b1;
        tick(1'b1);
        dump_req = 1'b0;
        repeat (3) tick(1'b1);
        chk("r034_drain_active", 32'(o_dump_active), 32'd1);
        chk("r034_drain_nostart", 32'(ob_start_dump), 32'd0);
        engine_busy = 1'b0;
        tick(1'b1);
        chk("r034_start1", 32'(ob_start_dump), 32'd1);
        dump_req = 1'b1; engine_busy = 1'b1;
        tick(1'b1);
        dump_req = 1'b0;
        repeat (9) tick(1'b1);
        engine_busy = 1'b0;
        repeat (3) tick(1'b1);
        chk("r034_start2", 32'(ob_start_dump), 32'd1);
        engine_busy = 1'b1;
        repeat (2) tick(1'b1);
        engine_busy = 1'b0;
        repeat (3) tick(1'b1);
        chk("r034_pulses", 32'(pulses), 32'd2);
        chk("r034_idle", 32'(o_dump_active), 32'd0);
        chk("r034_no_tmo", 32'(o_dump_timeout), 32'd0);

        // Dump with engine never going busy
        do_reset();
        active_cycles = 0;
        dump_req = 1'b1;
        tick(1'b1);
        dump_req = 1'b0;
        for (int i = 0; i < TMO + 50; i++) begin
            tick(1'b1);
            if (o_dump_timeout) break;
        end
        chk("r035_timeout", 32'(o_dump_timeout), 32'd1);
        chk("r035_active_cycles", 32'(active_cycles), 32'(TMO + 2));
        tick(1'b1);
        chk("r035_back_to_run", 32'(o_dump_active), 32'd0);
        net_q.push_back(32'h77); present();
        repeat (3) tick(1'b1);
        chk("r035_traffic_after", 32'(o_cnt_net), 32'd1);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            i_enable    = ($urandom_range(0, 9) != 0);
            engine_busy = ($urandom_range(0, 4) == 0);
            dump_req    = ($urandom_range(0, 79) == 0);
            rst_engine  = ($urandom_range(0, 599) == 0);
            net_hold    = ($urandom_range(0, 5) == 0);
            bot_hold    = ($urandom_range(0, 5) == 0);
            if (net_q.size() < 8 && $urandom_range(0, 2) != 0)
                net_q.push_back(($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom));
            if (bot_q.size() < 8 && $urandom_range(0, 2) != 0)
                bot_q.push_back(($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom));
            present();
            tick(1'b1);
        end
        rst_engine = 1'b0; dump_req = 1'b0;

        // Reset in the middle of DRAIN abandons the dump
        do_reset();
        engine_busy = 1'b1;
        dump_req = 1'b1;
        tick(1'b1);
        dump_req = 1'b0;
        repeat (2) tick(1'b1);
        chk("r036_in_drain", 32'(o_dump_active), 32'd1);
        pulses = 0;
        rst_engine = 1'b1;
        tick(1'b1);
        rst_engine = 1'b0;
        engine_busy = 1'b0;
        repeat (4) tick(1'b1);
        chk("r036_no_start", 32'(pulses), 32'd0);
        chk("r036_active", 32'(o_dump_active), 32'd0);
        chk("r036_valid", 32'(ob_input_valid), 32'd0);
        chk("r036_data", ob_input_data, 32'd0);
        chk("r036_tmo", 32'(o_dump_timeout), 32'd0);

        // Long net stream saturates the forward counter
        do_reset();
        stream_mode = 1'b1;
        present();
        for (int i = 0; i < 70000; i++) tick(i % 4096 == 0);
        chk("r036_cnt_sat", 32'(o_cnt_net), 32'h0000_FFFF);
        chk("r036_nop_zero", 32'(o_cnt_nop), 32'd0);
        stream_mode = 1'b0;
        present();
        repeat (2) tick(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ob_input_arbiter.md
OB_INPUT_ARBITER -- requirements
Module: ob_input_arbiter

Interface
REQ-001 SHALL use a single clock; reset is synchronous and active-high: clk_engine and rst_engine.
REQ-002 SHALL have parameter BURST_MAX, default 4, max consecutive accepted words per source while the other source is requesting.
REQ-003 SHALL have parameter DUMP_TIMEOUT, default 1024, cycles allowed for engine_busy to rise after a start_dump pulse.
REQ-004 SHALL have ports, in this order:
- clk_engine  in  1  200 MHz engine clock
- rst_engine  in  1  sync active-high reset
- i_enable  in  1  arbitration enable from system manager
- net_dout  in  32  FWFT input-FIFO word
- net_empty  in  1  input FIFO empty
- net_rd_en  out  1  input FIFO pop
- bot_data  in  32  market-bot order word
- bot_valid  in  1  bot word valid
- bot_ready  out  1  bot word accepted
- dump_req  in  1  single-cycle dump request pulse
- engine_busy  in  1  order book busy
- ob_input_valid  out  1  order word valid to engine
- ob_input_data  out  32  order word to engine
- ob_start_dump  out  1  single-cycle dump trigger to engine
- o_dump_active  out  1  high in any dump state
- o_cnt_net  out  16  forwarded net words, saturating
- o_cnt_bot  out  16  forwarded bot words, saturating
- o_cnt_nop  out  16  zero words dropped, saturating
- o_dump_timeout  out  1  sticky dump-timeout error

Function
REQ-005 SHALL implement states ARB_RUN, ARB_DRAIN, ARB_DUMP, ARB_DUMP_WAIT.
REQ-006 Handshake: a word is accepted in a cycle only if state is ARB_RUN, i_enable=1 and engine_busy=0; net_rd_en and bot_ready are combinational from registered state and inputs, with zero latency.
REQ-007 Requests: net_req=!net_empty; bot_req=bot_valid.
REQ-008 Only one source is accepted per cycle, so net_rd_en and bot_ready are never both high.
REQ-009 Arbitration, single requester: that source is granted.
REQ-010 Arbitration, both requesting: the last-granted source keeps the grant until burst_cnt==BURST_MAX, then the grant switches; burst_cnt resets to 1 on a switch and increments on each same-source accept.
REQ-011 After reset, last-granted source is net.
REQ-012 ob_input_data SHALL equal the accepted word.
REQ-013 ob_input_valid=1 only when the accepted word is nonzero.
REQ-014 A zero word SHALL still be popped or acked, not forwarded, increments o_cnt_nop, and does not advance burst_cnt.
REQ-015 o_cnt_net or o_cnt_bot SHALL increment by 1 per forwarded word and hold at 16'hFFFF.
REQ-016 dump_req SHALL set a dump_pending flag in any state; a request while the flag is already set merges into it.
REQ-017 ARB_RUN -> ARB_DRAIN when dump_pending=1; the same-cycle accept is still allowed.
REQ-018 ARB_DRAIN: no accepts; -> ARB_DUMP on the first cycle with engine_busy=0.
REQ-019 ARB_DUMP: ob_start_dump=1 for exactly one cycle, dump_pending cleared, -> ARB_DUMP_WAIT.
REQ-020 A dump_req arriving in the same cycle as ARB_DUMP SHALL keep dump_pending set.
REQ-021 ARB_DUMP_WAIT: -> ARB_RUN when engine_busy falls after having been seen high.
REQ-022 ARB_DUMP_WAIT timeout: if engine_busy stays low for DUMP_TIMEOUT cycles, -> ARB_RUN and o_dump_timeout set until reset.
REQ-023 The dump sequence SHALL proceed regardless of i_enable.
REQ-024 o_dump_active=1 in ARB_DRAIN, ARB_DUMP and ARB_DUMP_WAIT.

Reset
REQ-025 On rst_engine=1 at a clock edge, the block SHALL enter ARB_RUN and clear dump_pending, burst_cnt, all counters and o_dump_timeout.
REQ-026 Reset values: net_rd_en, bot_ready, ob_input_valid, ob_start_dump and o_dump_active =0; ob_input_data=0.
REQ-027 Reset mid-dump SHALL abandon the dump with no start_dump issued.
REQ-028 While rst_engine=1, no accepts SHALL occur.

Structure
REQ-029 The state encoding, ARB_* constants and the 16-bit counter width SHALL reside in the shared package ob_ctrl_pkg.
REQ-030 The three counters SHALL be instances of one sub-module, sat_counter16.

Verification
REQ-031 Net only, 3 words 0x11,0x00,0x22, busy=0 -> ob_input_valid for 0x11 and 0x22, o_cnt_net=2, o_cnt_nop=1.
REQ-032 Both sources continuously valid, BURST_MAX=4 -> accept order net x4, bot x4, net x4.
REQ-033 engine_busy=1 while words are pending -> net_rd_en=bot_ready=0 until busy falls.
REQ-034 dump_req while busy=1 -> ARB_DRAIN, start_dump one cycle after busy falls; busy high 10 cycles -> back to ARB_RUN; second dump_req in the ARB_DUMP cycle -> second dump issued.
REQ-035 dump with busy never rising -> after 1024 cycles o_dump_timeout=1 and ARB_RUN resumes.
REQ-036 Counter preloaded near limit with 70000 net words -> o_cnt_net=16'hFFFF; rst_engine mid-ARB_DRAIN -> no start_dump, all outputs at reset values.
